// File: rtl/alu_exec.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle ops produce a registered result with a latency of 1.
// MUL is an iterative shift-add that takes MUL_CYCLES cycles in total.
module alu_exec #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             bad_op
);

  // ALU operation encodings produced by the decoder
  localparam logic [7:0] ALUOP_ADD      = 8'h00;
  localparam logic [7:0] ALUOP_SUB      = 8'h01;
  localparam logic [7:0] ALUOP_LDB      = 8'h02;
  localparam logic [7:0] ALUOP_LDW      = 8'h03;
  localparam logic [7:0] ALUOP_STB      = 8'h04;
  localparam logic [7:0] ALUOP_STW      = 8'h05;
  localparam logic [7:0] ALUOP_MOV      = 8'h06;
  localparam logic [7:0] ALUOP_BEQ      = 8'h07;
  localparam logic [7:0] ALUOP_JUMP     = 8'h08;
  localparam logic [7:0] ALUOP_TLBWRITE = 8'h09;
  localparam logic [7:0] ALUOP_IRET     = 8'h0A;
  localparam logic [7:0] ALUOP_MUL      = 8'h0B;

  // Multiplier bits consumed per busy cycle (ceil), so the whole operand
  // is covered in exactly MUL_CYCLES-1 iterations.
  localparam int STEP = (WIDTH + MUL_CYCLES - 2) / (MUL_CYCLES - 1);
  localparam int CW   = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             bad_op_q, bad_op_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             mul_zero_q, mul_zero_d;

  logic             accept_s;
  logic [WIDTH-1:0] mul_sum_s;
  logic [WIDTH:0]   single_s;

  // Single-cycle datapath: returns {bad_op, result}. Unknown codes give 0.
  function automatic logic [WIDTH:0] exec_single(
    input logic [7:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] r;
    case (op)
      ALUOP_ADD, ALUOP_LDB, ALUOP_LDW,
      ALUOP_STB, ALUOP_STW, ALUOP_JUMP:  r = {1'b0, a + b};
      ALUOP_SUB, ALUOP_BEQ:              r = {1'b0, a - b};
      ALUOP_MOV:                         r = {1'b0, b};
      ALUOP_TLBWRITE, ALUOP_IRET:        r = {1'b0, a};
      default:                           r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign bad_op    = bad_op_q;
  assign single_s  = exec_single(aluop, op_a, op_b);

  // One shift-add iteration: add the shifted multiplicand for each of the
  // low STEP multiplier bits to the running product.
  always_comb begin
    mul_sum_s = acc_q;
    for (int i = 0; i < STEP; i++) begin
      if (mul_b_q[i]) begin
        mul_sum_s = mul_sum_s + (mul_a_q << i);
      end else begin
        mul_sum_s = mul_sum_s;
      end
    end
  end

  // Next-state and datapath control for IDLE / MUL_BUSY / HOLD.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    bad_op_d    = bad_op_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    mul_zero_d  = mul_zero_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && !out_ready) begin
          // Consumer stalls: keep the presented result untouched.
          state_d = S_HOLD;
        end else if (accept_s && (aluop == ALUOP_MUL)) begin
          state_d     = S_MUL_BUSY;
          out_valid_d = 1'b0;
          mul_a_d     = op_a;
          mul_b_d     = op_b;
          acc_d       = {WIDTH{1'b0}};
          mul_zero_d  = (op_a == op_b);
          cnt_d       = CW'(MUL_CYCLES - 1);
        end else if (accept_s) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          result_d    = single_s[WIDTH-1:0];
          bad_op_d    = single_s[WIDTH];
          zero_d      = (op_a == op_b);
        end else begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      S_MUL_BUSY: begin
        acc_d   = mul_sum_s;
        mul_a_d = mul_a_q << STEP;
        mul_b_d = mul_b_q >> STEP;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last iteration lands directly in the output register.
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          result_d    = mul_sum_s;
          zero_d      = mul_zero_q;
          bad_op_d    = 1'b0;
          cnt_d       = {CW{1'b0}};
        end else begin
          state_d = S_MUL_BUSY;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        cnt_d       = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      bad_op_q    <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      mul_a_q     <= {WIDTH{1'b0}};
      mul_b_q     <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      mul_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      bad_op_q    <= bad_op_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      mul_zero_q  <= mul_zero_d;
    end
  end

endmodule
